// File: rtl/pq_arbiter_pkg.sv
// Shared types for the priority-queue front-end arbiter: opcodes, response
// status, FSM states and the issue plan computed at grant time.
package pq_arbiter_pkg;

  typedef enum logic [1:0] {OP_RSVD, OP_ENQ, OP_DEQ, OP_REPLACE} op_e;
  typedef enum logic [1:0] {ST_OK, ST_FULL, ST_EMPTY, ST_ILLEGAL} status_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_e;

  typedef struct packed {
    logic    wrt;
    logic    rd;
    status_e status;
  } plan_t;

  // Which strobes an op needs given the queue flags, and the status it earns.
  function automatic plan_t plan_op(op_e op, logic full, logic empty);
    plan_t p;
    p.wrt    = 1'b0;
    p.rd     = 1'b0;
    p.status = ST_OK;
    case (op)
      OP_ENQ: begin
        p.wrt    = !full;
        p.status = full ? ST_FULL : ST_OK;
      end
      OP_DEQ: begin
        p.rd     = !empty;
        p.status = empty ? ST_EMPTY : ST_OK;
      end
      OP_REPLACE: begin
        p.wrt = 1'b1;
        p.rd  = !empty;
      end
      default: p.status = ST_ILLEGAL;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pq_arbiter_if.sv
// Requester handshakes, responses and queue-side strobes of the arbiter.
interface pq_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]                 i_req_valid;
  logic [NUM_REQ-1:0][1:0]            i_req_op;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]                 o_req_ready;
  logic [NUM_REQ-1:0]                 o_rsp_valid;
  logic [DATA_WIDTH-1:0]              o_rsp_data;
  logic [1:0]                         o_rsp_status;
  logic                               o_busy;
  logic                               o_pq_wrt;
  logic                               o_pq_read;
  logic [DATA_WIDTH-1:0]              o_pq_data;
  logic                               i_pq_full;
  logic                               i_pq_empty;
  logic [DATA_WIDTH-1:0]              i_pq_data;

  modport master (
    input  i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_status, o_busy,
           o_pq_wrt, o_pq_read, o_pq_data
  );

  modport slave (
    output i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_status, o_busy,
           o_pq_wrt, o_pq_read, o_pq_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [IDW-1:0] ptr;

  always_comb begin
    logic found;
    int   k;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

endmodule

// File: rtl/pq_arbiter.sv
// Shares one max-priority queue between NUM_REQ requesters: round-robin grant,
// one strobe per op, a settle window, then a one-hot response pulse.
module pq_arbiter
  import pq_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input logic          i_CLK,
  input logic          i_RST,
  pq_arbiter_if.master bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1 || QUEUE_SIZE < 1) begin : g_param_chk
    $error("pq_arbiter: SETTLE_CYCLES and QUEUE_SIZE must be at least 1");
  end

  state_e             state, state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gidx, id_q;
  logic [CW-1:0]      cnt;
  logic               cap_head;
  logic               any_req, advance;
  plan_t              plan;

  assign any_req = |bus.i_req_valid;
  assign advance = (state == S_IDLE) && any_req && !i_RST;
  // The queue is quiet while we sit in IDLE, so flags seen at grant time are
  // the ones ISSUE would see; deciding here lets the strobes be registered.
  assign plan    = plan_op(op_e'(bus.i_req_op[gidx]), bus.i_pq_full, bus.i_pq_empty);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (i_CLK),
    .rst      (i_RST),
    .req      (bus.i_req_valid),
    .advance  (advance),
    .grant    (grant),
    .grant_idx(gidx)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (any_req) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = (bus.o_pq_wrt || bus.o_pq_read) ? S_SETTLE : S_RESP;
      S_SETTLE: if (cnt == '0) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy      = (state != S_IDLE);
    bus.o_req_ready = advance ? grant : '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.o_rsp_valid[i] = (state == S_RESP) && (id_q == IDW'(i));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      id_q             <= '0;
      cnt              <= '0;
      cap_head         <= 1'b0;
      bus.o_pq_wrt     <= 1'b0;
      bus.o_pq_read    <= 1'b0;
      bus.o_pq_data    <= '0;
      bus.o_rsp_data   <= '0;
      bus.o_rsp_status <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          id_q             <= gidx;
          bus.o_pq_wrt     <= plan.wrt;
          bus.o_pq_read    <= plan.rd;
          bus.o_pq_data    <= plan.wrt ? bus.i_req_data[gidx] : '0;
          bus.o_rsp_status <= plan.status;
          bus.o_rsp_data   <= '0;
          cap_head         <= plan.wrt && !plan.rd;
        end
        S_ISSUE: begin
          bus.o_pq_wrt  <= 1'b0;
          bus.o_pq_read <= 1'b0;
          cnt           <= CW'(SETTLE_CYCLES - 1);
          // Reads return the head as it stood before the queue reacts.
          if (bus.o_pq_read) bus.o_rsp_data <= bus.i_pq_data;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            if (cap_head) bus.o_rsp_data <= bus.i_pq_data;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter with a behavioural max-priority queue attached.
module tb_pq_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int QS = 64;

  localparam int OP_RSVD = 0, OP_ENQ = 1, OP_DEQ = 2, OP_REP = 3;
  localparam int ST_OK = 0, ST_FULL = 1, ST_EMPTY = 2, ST_ILL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q_clr = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  pq_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  pq_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(4)) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural queue: unsorted storage, head is the current maximum.
  int mem [QS];
  int qn = 0;
  int hval, hidx;

  always_comb begin
    hval = 0;
    hidx = 0;
    for (int i = 0; i < QS; i++)
      if (i < qn && mem[i] > hval) begin
        hval = mem[i];
        hidx = i;
      end
    bus.i_pq_data  = hval[DW-1:0];
    bus.i_pq_full  = (qn == QS);
    bus.i_pq_empty = (qn == 0);
  end

  always @(posedge clk) begin
    if (q_clr) qn <= 0;
    else if (bus.o_pq_wrt && bus.o_pq_read) mem[hidx] <= int'(bus.o_pq_data);
    else if (bus.o_pq_wrt && qn < QS) begin
      mem[qn] <= int'(bus.o_pq_data);
      qn      <= qn + 1;
    end else if (bus.o_pq_read && qn > 0) begin
      mem[hidx] <= mem[qn-1];
      qn        <= qn - 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_q();
    @(posedge clk); #1 q_clr = 1'b1;
    @(posedge clk); #1 q_clr = 1'b0;
  endtask

  // Single requester op: checks grant, strobes, latency and response.
  task automatic run_op(input int id, input int op, input int val, input int st,
                        input int dv, input bit wr, input bit rd);
    int n, t;
    bus.i_req_valid[id] = 1'b1;
    bus.i_req_op[id]    = op[1:0];
    bus.i_req_data[id]  = val[DW-1:0];
    #1;
    n = 0;
    while (bus.o_req_ready[id] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("grant", int'(bus.o_req_ready), 1 << id);
    t = cyc;
    @(posedge clk); #1;
    bus.i_req_valid[id] = 1'b0;
    #1;
    chk("wrt", int'(bus.o_pq_wrt), int'(wr));
    chk("read", int'(bus.o_pq_read), int'(rd));
    chk("busy", int'(bus.o_busy), 1);
    if (wr) chk("pq_data", int'(bus.o_pq_data), val);
    @(posedge clk); #1;
    chk("strobe_width", int'({bus.o_pq_wrt, bus.o_pq_read}), 0);
    n = 0;
    while (bus.o_rsp_valid == '0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", cyc - t, (wr || rd) ? 6 : 2);
    chk("rsp_valid", int'(bus.o_rsp_valid), 1 << id);
    chk("rsp_data", int'(bus.o_rsp_data), dv);
    chk("rsp_status", int'(bus.o_rsp_status), st);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, prev, seen;
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_data  = '0;
    q_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q_clr = 1'b0;
    #1;
    chk("rst_ready", int'(bus.o_req_ready), 0);
    chk("rst_rsp_valid", int'(bus.o_rsp_valid), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_strobes", int'({bus.o_pq_wrt, bus.o_pq_read}), 0);
    chk("rst_rsp_data", int'(bus.o_rsp_data), 0);

    // Single enqueue: new head comes back as the response.
    run_op(2, OP_ENQ, 100, ST_OK, 100, 1, 0);

    // Four simultaneous requesters from a reset pointer: 0,1,2,3, seven apart.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_q();
    for (int k = 0; k < NR; k++) begin
      bus.i_req_op[k]   = 2'b01;
      bus.i_req_data[k] = DW'(10 * (k + 1));
    end
    bus.i_req_valid = 4'hF;
    #1;
    prev = 0;
    for (int k = 0; k < NR; k++) begin
      n = 0;
      while (bus.o_req_ready == '0 && n < 20) begin @(posedge clk); #1; n++; end
      chk("rr_grant", int'(bus.o_req_ready), 1 << k);
      if (k > 0) chk("rr_gap", cyc - prev, 7);
      prev = cyc;
      @(posedge clk); #1;
      bus.i_req_valid[k] = 1'b0;
      #1;
    end
    n = 0;
    while (bus.o_rsp_valid != 4'b1000 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rr_last_rsp", int'(bus.o_rsp_valid), 8);
    chk("rr_last_data", int'(bus.o_rsp_data), 40);
    @(posedge clk); #1;

    // Empty dequeue, then enqueue/dequeue round trip.
    clear_q();
    run_op(1, OP_DEQ, 0, ST_EMPTY, 0, 0, 0);
    run_op(1, OP_ENQ, 7, ST_OK, 7, 1, 0);
    run_op(1, OP_DEQ, 0, ST_OK, 7, 0, 1);
    chk("empty_after", int'(bus.i_pq_empty), 1);

    // Fill to capacity; enqueue rejected, replace swaps out the head.
    clear_q();
    run_op(0, OP_ENQ, 1000, ST_OK, 1000, 1, 0);
    for (int v = 1; v < QS; v++) run_op(0, OP_ENQ, v, ST_OK, 1000, 1, 0);
    chk("full", int'(bus.i_pq_full), 1);
    run_op(2, OP_ENQ, 5, ST_FULL, 0, 0, 0);
    run_op(2, OP_REP, 5, ST_OK, 1000, 1, 1);
    chk("head_after_rep", int'(bus.i_pq_data), 63);

    // Reserved op from req3; pointer wraps so req0 wins next.
    clear_q();
    run_op(3, OP_RSVD, 0, ST_ILL, 0, 0, 0);
    for (int k = 0; k < NR; k++) bus.i_req_op[k] = 2'b01;
    bus.i_req_valid = 4'hF;
    #1;
    chk("wrap_grant", int'(bus.o_req_ready), 1);

    // Reset while settling: outputs clear, no response, pointer back to 0.
    @(posedge clk); #1;
    bus.i_req_valid = '0;
    #1;
    chk("abort_wrt", int'(bus.o_pq_wrt), 1);
    @(posedge clk); #1;
    chk("abort_busy", int'(bus.o_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(bus.o_req_ready), 0);
    chk("abort_busy0", int'(bus.o_busy), 0);
    chk("abort_strobes", int'({bus.o_pq_wrt, bus.o_pq_read}), 0);
    chk("abort_pq_data", int'(bus.o_pq_data), 0);
    chk("abort_rsp", int'({bus.o_rsp_valid, bus.o_rsp_status}), 0);
    chk("abort_rsp_data", int'(bus.o_rsp_data), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.o_rsp_valid != '0) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    bus.i_req_valid = 4'hF;
    #1;
    chk("post_rst_grant", int'(bus.o_req_ready), 1);
    @(posedge clk); #1;
    bus.i_req_valid = '0;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
